// File: rtl/alu_operand_stage.sv
// ALU operand select with bypass forwarding, hazard stall and ID/EX register.
// Operands resolve combinationally and are held until the ALU takes them.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int NBYP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           asel,
  input  logic [1:0]           bsel,
  input  logic [REGW-1:0]      rs1_addr,
  input  logic [REGW-1:0]      rs2_addr,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      imm,
  input  logic [NBYP-1:0]      byp_valid,
  input  logic [NBYP-1:0]      byp_rdy,
  input  logic [NBYP*REGW-1:0] byp_addr,
  input  logic [NBYP*XLEN-1:0] byp_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      a,
  output logic [XLEN-1:0]      b,
  output logic                 fwd_a,
  output logic                 fwd_b,
  output logic [31:0]          stall_cnt
);

  typedef struct packed {
    logic            hit;
    logic            rdy;
    logic [XLEN-1:0] data;
  } src_t;

  // Scan oldest to youngest so the youngest match wins.
  function automatic src_t resolve(
    input logic [REGW-1:0]      addr,
    input logic [XLEN-1:0]      rf,
    input logic [NBYP-1:0]      bv,
    input logic [NBYP-1:0]      br,
    input logic [NBYP*REGW-1:0] ba,
    input logic [NBYP*XLEN-1:0] bd
  );
    src_t r;
    r.hit  = 1'b0;
    r.rdy  = 1'b1;
    r.data = rf;
    for (int i = NBYP - 1; i >= 0; i--) begin
      if (bv[i] && ba[i*REGW +: REGW] == addr
          && addr != '0) begin
        r.hit  = 1'b1;
        r.rdy  = br[i];
        r.data = bd[i*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  src_t            ra;
  src_t            rb;
  logic            use_a;
  logic            use_b;
  logic            hazard;
  logic            take;
  logic            stall_inc;
  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;

  always_comb begin
    ra = resolve(rs1_addr, rs1_data, byp_valid,
                 byp_rdy, byp_addr, byp_data);
    rb = resolve(rs2_addr, rs2_data, byp_valid,
                 byp_rdy, byp_addr, byp_data);
  end

  assign use_a  = (asel == 2'd0);
  assign use_b  = (bsel == 2'd0);
  assign hazard = (use_a && ra.hit && !ra.rdy)
               || (use_b && rb.hit && !rb.rdy);

  always_comb begin
    a_next = '0;
    unique case (1'b1)
      (asel == 2'd0): a_next = ra.data;
      (asel == 2'd1): a_next = pc;
      default:        a_next = '0;
    endcase
  end

  always_comb begin
    b_next = '0;
    unique case (1'b1)
      (bsel == 2'd0): b_next = rb.data;
      (bsel == 2'd1): b_next = imm;
      (bsel == 2'd2): b_next = XLEN'(4);
      default:        b_next = '0;
    endcase
  end

  assign in_ready  = (!out_valid || out_ready)
                  && !hazard && !flush;
  assign take      = in_valid && in_ready;
  assign stall_inc = in_valid && hazard && !flush
                  && (stall_cnt != 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      fwd_a     <= 1'b0;
      fwd_b     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
      a         <= a_next;
      b         <= b_next;
      fwd_a     <= use_a && ra.hit;
      fwd_b     <= use_b && rb.hit;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_inc) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a per-cycle reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  asel;
  logic [1:0]  bsel;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [1:0]  byp_valid;
  logic [1:0]  byp_rdy;
  logic [9:0]  byp_addr;
  logic [63:0] byp_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] stall_cnt;

  logic        bv [2];
  logic        br [2];
  logic [4:0]  ba [2];
  logic [31:0] bd [2];

  int checks = 0;
  int errors = 0;

  assign byp_valid = {bv[1], bv[0]};
  assign byp_rdy   = {br[1], br[0]};
  assign byp_addr  = {ba[1], ba[0]};
  assign byp_data  = {bd[1], bd[0]};

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .asel(asel), .bsel(bsel),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .imm(imm),
    .byp_valid(byp_valid), .byp_rdy(byp_rdy),
    .byp_addr(byp_addr), .byp_data(byp_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt)
  );

  task automatic cmp(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference: first matching entry in priority order wins.
  task automatic find(input logic [4:0] s,
                      input logic [31:0] rf,
                      output logic hit,
                      output logic ok,
                      output logic [31:0] d);
    hit = 1'b0;
    ok  = 1'b1;
    d   = rf;
    if (s != 5'd0) begin
      for (int i = 0; i < 2; i++) begin
        if (bv[i] && ba[i] == s) begin
          hit = 1'b1;
          ok  = br[i];
          d   = bd[i];
          break;
        end
      end
    end
  endtask

  logic        m_v;
  logic [31:0] m_a, m_b;
  logic        m_fa, m_fb;
  logic [31:0] m_cnt;
  logic        e_hz, e_rdy, e_fa, e_fb;
  logic [31:0] e_a, e_b;

  always_comb begin
    logic h1, k1, h2, k2;
    logic [31:0] d1, d2;
    h1 = 1'b0; k1 = 1'b1; d1 = '0;
    h2 = 1'b0; k2 = 1'b1; d2 = '0;
    find(rs1_addr, rs1_data, h1, k1, d1);
    find(rs2_addr, rs2_data, h2, k2, d2);
    e_a  = (asel == 2'd0) ? d1 :
           (asel == 2'd1) ? pc : 32'd0;
    e_b  = (bsel == 2'd0) ? d2 :
           (bsel == 2'd1) ? imm :
           (bsel == 2'd2) ? 32'd4 : 32'd0;
    e_fa = (asel == 2'd0) && h1;
    e_fb = (bsel == 2'd0) && h2;
    e_hz = ((asel == 2'd0) && !k1)
        || ((bsel == 2'd0) && !k2);
    e_rdy = (!m_v || out_ready) && !e_hz && !flush;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= 1'b0; m_a <= '0; m_b <= '0;
      m_fa <= 1'b0; m_fb <= 1'b0; m_cnt <= '0;
    end else begin
      if (flush) m_v <= 1'b0;
      else if (in_valid && e_rdy) begin
        m_v <= 1'b1; m_a <= e_a; m_b <= e_b;
        m_fa <= e_fa; m_fb <= e_fb;
      end else if (out_ready) m_v <= 1'b0;
      if (in_valid && e_hz && !flush
          && m_cnt != 32'hFFFF_FFFF)
        m_cnt <= m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    cmp("m_out_valid", 32'(out_valid), 32'(m_v));
    cmp("m_a", a, m_a);
    cmp("m_b", b, m_b);
    cmp("m_fwd_a", 32'(fwd_a), 32'(m_fa));
    cmp("m_fwd_b", 32'(fwd_b), 32'(m_fb));
    cmp("m_stall_cnt", stall_cnt, m_cnt);
    cmp("m_in_ready", 32'(in_ready), 32'(e_rdy));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    asel = 2'd0; bsel = 2'd0; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    rs1_data = '0; rs2_data = '0;
    pc = '0; imm = '0;
    for (int i = 0; i < 2; i++) begin
      bv[i] = 1'b0; br[i] = 1'b1;
      ba[i] = '0; bd[i] = '0;
    end
    #2;
    cmp("rst_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_a", a, 32'd0);
    cmp("rst_stall", stall_cnt, 32'd0);
    cmp("rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;

    // pc / imm path
    asel = 2'd1; bsel = 2'd1;
    pc = 32'h8000_0000; imm = 32'h10;
    in_valid = 1'b1;
    tick();
    cmp("t1_valid", 32'(out_valid), 32'd1);
    cmp("t1_a", a, 32'h8000_0000);
    cmp("t1_b", b, 32'h10);
    cmp("t1_fwd", {30'd0, fwd_a, fwd_b}, 32'd0);

    // youngest bypass wins
    asel = 2'd0; bsel = 2'd0;
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    rs1_data = 32'h1111; rs2_data = 32'h2222;
    bv[0] = 1; ba[0] = 5; bd[0] = 32'hAAAA; br[0] = 1;
    bv[1] = 1; ba[1] = 5; bd[1] = 32'hBBBB; br[1] = 1;
    tick();
    cmp("t2_a", a, 32'hAAAA);
    cmp("t2_b", b, 32'hAAAA);
    cmp("t2_fwd", {30'd0, fwd_a, fwd_b}, 32'd3);
    bv[0] = 0;
    tick();
    cmp("t2_a_old", a, 32'hBBBB);
    cmp("t2_b_old", b, 32'hBBBB);

    // x0 never forwards; constant 4
    rs1_addr = 5'd0; rs1_data = 32'd0;
    bv[0] = 1; ba[0] = 0; bd[0] = 32'h1234; br[0] = 1;
    bv[1] = 0; bsel = 2'd2;
    tick();
    cmp("t3_a", a, 32'd0);
    cmp("t3_fwd_a", 32'(fwd_a), 32'd0);
    cmp("t3_b", b, 32'd4);

    // pending load on rs2
    asel = 2'd1; pc = 32'h100;
    bsel = 2'd0; rs2_addr = 5'd7; rs2_data = 32'h99;
    ba[0] = 7; bd[0] = 32'd0; br[0] = 0;
    #1;
    cmp("t4_in_ready", 32'(in_ready), 32'd0);
    tick(); tick(); tick();
    cmp("t4_drained", 32'(out_valid), 32'd0);
    cmp("t4_stall", stall_cnt, 32'd3);
    br[0] = 1; bd[0] = 32'h55;
    tick();
    cmp("t4_valid", 32'(out_valid), 32'd1);
    cmp("t4_b", b, 32'h55);
    cmp("t4_fwd_b", 32'(fwd_b), 32'd1);
    br[0] = 0; bsel = 2'd1;
    #1;
    cmp("t4_imm_ready", 32'(in_ready), 32'd1);
    tick();
    cmp("t4_imm_b", b, 32'h10);
    cmp("t4_imm_stall", stall_cnt, 32'd3);

    // back-pressure then drain+fill
    out_ready = 1'b0;
    pc = 32'h200; imm = 32'h20;
    #1;
    cmp("t5_in_ready", 32'(in_ready), 32'd0);
    tick();
    cmp("t5_hold_a", a, 32'h100);
    cmp("t5_hold_b", b, 32'h10);
    out_ready = 1'b1;
    #1;
    cmp("t5_ready", 32'(in_ready), 32'd1);
    tick();
    cmp("t5_valid", 32'(out_valid), 32'd1);
    cmp("t5_a", a, 32'h200);
    cmp("t5_b", b, 32'h20);

    // flush kills held and incoming
    flush = 1'b1; pc = 32'h300;
    #1;
    cmp("t6_in_ready", 32'(in_ready), 32'd0);
    tick();
    cmp("t6_valid", 32'(out_valid), 32'd0);
    cmp("t6_a", a, 32'h200);
    flush = 1'b0;

    // async reset mid-stall with a held entry
    out_ready = 1'b0; pc = 32'h400; imm = 32'h40;
    tick();
    cmp("t7_valid", 32'(out_valid), 32'd1);
    bsel = 2'd0;
    tick(); tick();
    cmp("t7_stall", stall_cnt, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    cmp("t7_rst_valid", 32'(out_valid), 32'd0);
    cmp("t7_rst_a", a, 32'd0);
    cmp("t7_rst_b", b, 32'd0);
    cmp("t7_rst_stall", stall_cnt, 32'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
